mips_regbank_sb: RTL and testbench

//  Parametrised register bank and issue scoreboard for the single-clock mips32 pipeline.

---
 rtl/mips_pkg.sv | 14 +
 rtl/mips_scoreboard.sv | 38 +++
 rtl/mips_regbank_sb.sv | 65 ++++++
 tb/tb_mips_regbank_sb.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, the hardwired-zero register index and opcodes used across the mips32 core.
package mips_pkg;
  localparam int DATA_W_D = 32;
  localparam int NREGS_D = 32;
  localparam int ADDR_W_D = 5;
  localparam int R0 = 0;
  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR = 6'b000011;
  localparam logic [5:0] OP_SLT = 6'b000100;
  localparam logic [5:0] OP_MUL = 6'b000101;
  localparam logic [5:0] OP_HLT = 6'b111111;
endpackage

// File: rtl/mips_scoreboard.sv
// mips_scoreboard: in-flight destination tracking, RAW/WAW hazard detection and halt drain status.
module mips_scoreboard
  import mips_pkg::*;
#(
  parameter int NREGS = NREGS_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              issue_valid,
  input  logic              issue_wr,
  input  logic [ADDR_W-1:0] issue_rs,
  input  logic [ADDR_W-1:0] issue_rt,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              issue_ready,
  output logic              drained,
  output logic [NREGS-1:0]  pending
);
  logic [NREGS-1:0] clr, set, eff;
  logic haz;
  always_comb begin
    clr = '0;
    set = '0;
    if (wb_valid && wb_addr != ADDR_W'(R0)) clr[wb_addr] = 1'b1;
    // a register retiring this cycle no longer blocks issue
    eff = pending & ~clr;
    haz = eff[issue_rs] | eff[issue_rt] | (issue_wr & eff[issue_rd]);
    issue_ready = rst_n && !halt && !haz;
    if (issue_valid && issue_ready && issue_wr && issue_rd != ADDR_W'(R0)) set[issue_rd] = 1'b1;
    drained = rst_n && halt && pending == '0;
  end
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) pending <= '0;
    else pending <= (pending & ~clr) | set;
endmodule

// File: rtl/mips_regbank_sb.sv
// mips_regbank_sb: register bank with writeback bypass, issue scoreboard and saturating stall counter.
// Optional debug port enabled by MIPS_REGBANK_DBG_EN.
module mips_regbank_sb
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int NREGS = NREGS_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  input  logic                   halt,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_rs,
  input  logic [ADDR_W-1:0]      issue_rt,
  input  logic [ADDR_W-1:0]      issue_rd,
  input  logic                   issue_wr,
  output logic                   issue_ready,
  output logic [DATA_W-1:0]      rd_data_a,
  output logic [DATA_W-1:0]      rd_data_b,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic [NREGS-1:0]       pending,
  output logic                   drained,
  output logic [STALL_CNT_W-1:0] stall_cycles
`ifdef MIPS_REGBANK_DBG_EN
  ,
  input  logic                   dbg_we,
  input  logic [ADDR_W-1:0]      dbg_addr,
  input  logic [DATA_W-1:0]      dbg_wdata,
  output logic [DATA_W-1:0]      dbg_rdata
`endif
);
  logic [DATA_W-1:0] bank [NREGS];
  logic wb_en;
  assign wb_en = wb_valid && wb_addr != ADDR_W'(R0);
  mips_scoreboard #(.NREGS(NREGS), .ADDR_W(ADDR_W)) u_sb (
    .clk1(clk1), .rst_n(rst_n), .halt(halt), .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .issue_ready(issue_ready), .drained(drained), .pending(pending)
  );
  always_comb begin
    rd_data_a = (issue_rs == ADDR_W'(R0)) ? '0 : (wb_valid && wb_addr == issue_rs) ? wb_data : bank[issue_rs];
    rd_data_b = (issue_rt == ADDR_W'(R0)) ? '0 : (wb_valid && wb_addr == issue_rt) ? wb_data : bank[issue_rt];
  end
`ifdef MIPS_REGBANK_DBG_EN
  assign dbg_rdata = bank[dbg_addr];
`endif
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) bank[i] <= '0;
    end else begin
      if (wb_en) bank[wb_addr] <= wb_data;
`ifdef MIPS_REGBANK_DBG_EN
      // debug preload only while halted, and a same-address writeback takes precedence
      if (halt && dbg_we && dbg_addr != ADDR_W'(R0) && !(wb_en && wb_addr == dbg_addr))
        bank[dbg_addr] <= dbg_wdata;
`endif
    end
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) stall_cycles <= '0;
    else if (issue_valid && !issue_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
endmodule

// File: tb/tb_mips_regbank_sb.sv
// tb_mips_regbank_sb: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_mips_regbank_sb;
  localparam int SCW = 2;
  localparam int SMAX = (1 << SCW) - 1;
  logic clk1 = 0;
  logic rst_n, halt, issue_valid, issue_wr, issue_ready, wb_valid, drained;
  logic [4:0] issue_rs, issue_rt, issue_rd, wb_addr;
  logic [31:0] rd_data_a, rd_data_b, wb_data, pending;
  logic [SCW-1:0] stall_cycles;
`ifdef MIPS_REGBANK_DBG_EN
  logic dbg_we;
  logic [4:0] dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
`endif
  int checks = 0, failures = 0;
  logic [31:0] m_bank [32];
  bit m_inflight [32];
  int m_stall;
  logic [31:0] ep;
  bit er;

  mips_regbank_sb #(.DATA_W(32), .NREGS(32), .ADDR_W(5), .STALL_CNT_W(SCW)) dut (
    .clk1(clk1), .rst_n(rst_n), .halt(halt), .issue_valid(issue_valid), .issue_rs(issue_rs),
    .issue_rt(issue_rt), .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_ready(issue_ready),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .pending(pending), .drained(drained), .stall_cycles(stall_cycles)
`ifdef MIPS_REGBANK_DBG_EN
    , .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
`endif
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk1);
    #1;
  endtask

  task automatic clr();
    halt = 0; issue_valid = 0; issue_wr = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
`ifdef MIPS_REGBANK_DBG_EN
    dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
`endif
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 0) return 0;
    if (wb_valid && wb_addr == a) return wb_data;
    return m_bank[a];
  endfunction

  function automatic bit busy(input logic [4:0] r);
    return m_inflight[r] && !(wb_valid && wb_addr == r);
  endfunction

  // model: compare current outputs, then advance to the state after the coming edge
  always @(negedge clk1) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin m_bank[i] = 0; m_inflight[i] = 0; end
      m_stall = 0;
      chk("m_rst_pending", pending, 0);
      chk("m_rst_ready", issue_ready, 0);
      chk("m_rst_drained", drained, 0);
      chk("m_rst_stall", stall_cycles, 0);
      chk("m_rst_rd_a", rd_data_a, 0);
    end else begin
      er = !halt && !(busy(issue_rs) || busy(issue_rt) || (issue_wr && busy(issue_rd)));
      ep = 0;
      for (int i = 0; i < 32; i++) if (m_inflight[i]) ep[i] = 1;
      chk("m_ready", issue_ready, er);
      chk("m_rd_a", rd_data_a, mread(issue_rs));
      chk("m_rd_b", rd_data_b, mread(issue_rt));
      chk("m_pending", pending, ep);
      chk("m_drained", drained, halt && ep == 0);
      chk("m_stall", stall_cycles, m_stall);
`ifdef MIPS_REGBANK_DBG_EN
      chk("m_dbg_rdata", dbg_rdata, dbg_addr == 0 ? 32'h0 : m_bank[dbg_addr]);
      if (halt && dbg_we && dbg_addr != 0 && !(wb_valid && wb_addr == dbg_addr)) m_bank[dbg_addr] = dbg_wdata;
`endif
      if (issue_valid && !er) m_stall = (m_stall < SMAX) ? m_stall + 1 : SMAX;
      if (wb_valid && wb_addr != 0) begin m_bank[wb_addr] = wb_data; m_inflight[wb_addr] = 0; end
      if (issue_valid && er && issue_wr && issue_rd != 0) m_inflight[issue_rd] = 1;
    end
  end

  initial begin
    rst_n = 0; clr(); halt = 1;
    @(negedge clk1);
    chk("rst_ready", issue_ready, 0); chk("rst_drained_halt", drained, 0); chk("rst_stall", stall_cycles, 0);
    nx(); rst_n = 1; halt = 0;
    wb_valid = 1; wb_addr = 1; wb_data = 10; nx();
    wb_addr = 2; wb_data = 20;
    @(negedge clk1); chk("wb_nonpending", pending, 0); nx();
    clr(); issue_valid = 1; issue_wr = 1; issue_rs = 1; issue_rt = 2; issue_rd = 4;
    @(negedge clk1); chk("add_ready", issue_ready, 1); chk("add_a", rd_data_a, 10); chk("add_b", rd_data_b, 20); nx();
    issue_rs = 4; issue_rt = 3; issue_rd = 5;
    @(negedge clk1); chk("raw_stall", issue_ready, 0); chk("raw_pending", pending, 32'h10); nx();
    @(negedge clk1); chk("raw_stall2", issue_ready, 0); nx();
    wb_valid = 1; wb_addr = 4; wb_data = 30;
    @(negedge clk1); chk("raw_release", issue_ready, 1); chk("raw_bypass", rd_data_a, 30); nx();
    clr(); issue_valid = 1; issue_wr = 1; issue_rd = 4;
    @(negedge clk1); chk("raw_pend_r5", pending, 32'h20); chk("raw_stall_cnt", stall_cycles, 2); nx();
    clr();
    @(negedge clk1); chk("pend_30", pending, 32'h30); nx();
    issue_rs = 1; rst_n = 0; #1;
    chk("async_pending", pending, 0); chk("async_stall", stall_cycles, 0);
    chk("async_rd_a", rd_data_a, 0); chk("async_ready", issue_ready, 0);
    nx(); rst_n = 1;
    clr(); issue_valid = 1; issue_wr = 1; issue_rd = 7; nx();
    wb_valid = 1; wb_addr = 7; wb_data = 32'h77;
    @(negedge clk1); chk("setclr_ready", issue_ready, 1); nx();
    clr(); issue_rs = 7;
    @(negedge clk1); chk("setclr_pending", pending, 32'h80); chk("setclr_bank", rd_data_a, 32'h77); nx();
    clr(); wb_valid = 1; wb_addr = 7; wb_data = 32'h78; nx();
    clr(); wb_valid = 1; wb_addr = 0; wb_data = 32'hdead; issue_valid = 1; issue_wr = 1;
    @(negedge clk1); chk("r0_read", rd_data_a, 0); chk("r0_ready", issue_ready, 1); nx();
    clr();
    @(negedge clk1); chk("r0_pending", pending, 0); nx();
    issue_valid = 1; issue_wr = 1; issue_rd = 1; nx();
    issue_rd = 2; nx();
    clr(); halt = 1; issue_valid = 1;
    @(negedge clk1); chk("halt_ready", issue_ready, 0); chk("halt_drained", drained, 0); chk("halt_pending", pending, 32'h6); nx();
    wb_valid = 1; wb_addr = 1; wb_data = 5; nx();
    wb_addr = 2; wb_data = 6;
    @(negedge clk1); chk("drain_wait", drained, 0); nx();
    wb_valid = 0;
    @(negedge clk1); chk("drain_done", drained, 1); nx();
    clr(); rst_n = 0; nx(); rst_n = 1;
    issue_valid = 1; issue_wr = 1; issue_rd = 3; nx();
    issue_wr = 0; issue_rs = 3; issue_rd = 0;
    repeat (5) nx();
    clr();
    @(negedge clk1); chk("stall_saturate", stall_cycles, 3); nx();
    wb_valid = 1; wb_addr = 3; wb_data = 0; nx();
    clr();
`ifdef MIPS_REGBANK_DBG_EN
    halt = 1; dbg_we = 1; dbg_addr = 3; dbg_wdata = 25; nx();
    dbg_we = 0; issue_rs = 3;
    @(negedge clk1); chk("dbg_rdata", dbg_rdata, 25); chk("dbg_rd_a", rd_data_a, 25); nx();
    halt = 0; dbg_we = 1; dbg_wdata = 99; nx();
    dbg_we = 0;
    @(negedge clk1); chk("dbg_ignored", dbg_rdata, 25); nx();
    clr();
`endif
    for (int n = 0; n < 800; n++) begin
      clr();
      if ($urandom_range(0, 79) == 0) rst_n = 0;
      else begin
        rst_n = 1;
        halt = ($urandom_range(0, 9) == 0);
        issue_valid = ($urandom_range(0, 9) < 7);
        issue_wr = ($urandom_range(0, 9) < 7);
        issue_rs = 5'($urandom_range(0, 7));
        issue_rt = 5'($urandom_range(0, 7));
        issue_rd = 5'($urandom_range(0, 7));
        wb_valid = ($urandom_range(0, 9) < 4);
        wb_addr = 5'($urandom_range(0, 7));
        wb_data = $urandom;
`ifdef MIPS_REGBANK_DBG_EN
        dbg_we = ($urandom_range(0, 4) == 0);
        dbg_addr = 5'($urandom_range(0, 7));
        dbg_wdata = $urandom;
`endif
      end
      nx();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
